vga_cap_rx: RTL and testbench
=============================

Name: vga_cap_rx

Overview:
- Receive-side counterpart of the 800x600@60 VGA timing generator; consumes VGA_HSYNC/VSYNC/DE/DATA-style signals on the 40 MHz domain.
- Recovers pixel X/Y coordinates, checks line and frame geometry, and gates pixel writes to a capture buffer.
- Writes are issued only after timing lock is achieved.
- Used for loopback self-test of the video path and for frame capture.

Parameters:
- P_HDATA, 800, active pixels per line
- P_HTOTAL, 1056, clocks between HSYNC rising edges
- P_VDATA, 600, active lines per frame
- P_LOCK_FRAMES, 2, consecutive good frames required to lock (1..15)

Ports:
- CLK_40M  in  1  clock 40 MHz
- SYS_RST_N  in  1  system reset, asynchronous, active-low
- REG_CAP_EN  in  1  capture enable; low forces IDLE
- VIN_HSYNC  in  1  horizontal sync, active-high
- VIN_VSYNC  in  1  vertical sync, active-high
- VIN_DE  in  1  data enable
- VIN_DATA  in  9  pixel data
- CAP_WR_EN  out  1  pixel write strobe
- CAP_X  out  10  pixel column 0..P_HDATA-1
- CAP_Y  out  10  pixel row 0..P_VDATA-1
- CAP_DATA  out  9  pixel data aligned to CAP_WR_EN
- CAP_SOF  out  1  1-cycle pulse with first write of a frame (X=0, Y=0)
- CAP_LOCKED  out  1  high in LOCKED state
- CAP_ERR  out  1  1-cycle pulse on any geometry error
- CAP_ERR_CNT  out  8  saturating error count

Behaviour:
- Reset (SYS_RST_N=0): all outputs and internal registers are 0; state is IDLE.
- Stage 1: VIN_* registered unconditionally (hs1, vs1, de1, d1). Stage 2: hs2, vs2, de2 registered for edge detection.
- Edges:
  - vs_rise = vs1 & ~vs2; hs_rise = hs1 & ~hs2
  - de_rise = de1 & ~de2; de_fall = ~de1 & de2
- Pixel counter px (11 bits): cleared on de_rise; increments each cycle with de1=1. Saturates at 2047.
- Line-length check: on de_fall, px != P_HDATA -> error.
- Line counter ln (11 bits): cleared on vs_rise; increments on de_fall.
- Frame-height check: on vs_rise, when not in WAIT_VS, ln != P_VDATA -> error.
- Horizontal period counter hc (11 bits):
  - cleared on hs_rise; increments otherwise, saturating at 2047.
  - On hs_rise, when a previous hs_rise has been seen since entering WAIT_VS, hc+1 != P_HTOTAL -> error.
- DE must not be high while VSYNC is high (de1 & vs1) -> error.
- Simultaneous errors in one cycle count once.
- FSM:
  - IDLE: REG_CAP_EN=1 -> WAIT_VS.
  - WAIT_VS: vs_rise -> SYNC; good-frame count gcnt cleared.
  - SYNC: vs_rise with no error since the previous vs_rise -> gcnt+1. If gcnt+1 == P_LOCK_FRAMES -> LOCKED. Any error -> WAIT_VS.
  - LOCKED: any error -> WAIT_VS, CAP_LOCKED drops the next cycle.
  - From any state, REG_CAP_EN=0 -> IDLE next cycle; counters are cleared and CAP_ERR_CNT is retained.
- Error reporting: CAP_ERR pulses, and CAP_ERR_CNT increments (saturating at 255), only for errors detected in SYNC or LOCKED. Errors in WAIT_VS are ignored.
- Write output: in LOCKED with de1=1, the next cycle drives CAP_WR_EN=1, CAP_X=px[9:0] (pre-increment value), CAP_Y=ln[9:0], CAP_DATA=d1.
  - Latency from VIN_DE/VIN_DATA to CAP_WR_EN/CAP_DATA: 2 clocks.
  - Outside writes, CAP_X, CAP_Y and CAP_DATA hold their last value.
- Write gating: any write with px >= P_HDATA or ln >= P_VDATA is suppressed (CAP_WR_EN=0) and flagged as an error.
- CAP_SOF=1 together with the write at X=0, Y=0.
- Lock is entered only on vs_rise, so no partial frame is ever written.
- Reset mid-frame returns to IDLE immediately; no write is issued in the cycle after reset release.

Test Plan:
- Drive generator-equivalent 800x600 timing (HTOTAL 1056, 628 lines), REG_CAP_EN=1 -> CAP_LOCKED rises on the 3rd vs_rise (2 good frames). The following frame produces exactly 480000 CAP_WR_EN pulses, CAP_SOF once, last write X=799 Y=599, CAP_ERR_CNT=0.
- Locked, then one line with 799 DE cycles -> CAP_ERR pulse at that de_fall, CAP_LOCKED=0 next cycle, CAP_ERR_CNT=1, no writes until relock 3 vs_rise later.
- Locked, then one HSYNC period of 1055 clocks -> error, relock sequence; CAP_ERR_CNT increments by 1.
- Ramp VIN_DATA=X mod 512 -> every write has CAP_DATA==CAP_X[8:0]; write occurs exactly 2 clocks after the corresponding VIN_DE sample.
- Deassert REG_CAP_EN mid-frame for 10 clocks, then reassert -> IDLE, then WAIT_VS; CAP_ERR_CNT unchanged; CAP_LOCKED only after 2 full good frames.
- Pulse SYS_RST_N low mid-line while locked -> all outputs 0 within the reset; after release, no writes until relock; inject 300 errors -> CAP_ERR_CNT saturates at 255.

Source files
------------

// File: rtl/vga_cap_rx.sv
// VGA capture receiver: recovers pixel X/Y from 800x600 timing, checks geometry, and gates capture writes once locked.
// Latency: VIN_DE/VIN_DATA to CAP_WR_EN/CAP_DATA is 2 clocks. Lock and error outputs are registered.
// No backpressure: the video stream cannot be stalled, so writes are strobes that the capture buffer must accept.
module vga_cap_rx #(
  parameter int P_HDATA       = 800,
  parameter int P_HTOTAL      = 1056,
  parameter int P_VDATA       = 600,
  parameter int P_LOCK_FRAMES = 2
) (
  input  logic       CLK_40M,
  input  logic       SYS_RST_N,
  input  logic       REG_CAP_EN,
  input  logic       VIN_HSYNC,
  input  logic       VIN_VSYNC,
  input  logic       VIN_DE,
  input  logic [8:0] VIN_DATA,
  output logic       CAP_WR_EN,
  output logic [9:0] CAP_X,
  output logic [9:0] CAP_Y,
  output logic [8:0] CAP_DATA,
  output logic       CAP_SOF,
  output logic       CAP_LOCKED,
  output logic       CAP_ERR,
  output logic [7:0] CAP_ERR_CNT
);

  localparam logic [10:0] HDATA   = 11'(P_HDATA);
  localparam logic [10:0] VDATA   = 11'(P_VDATA);
  localparam logic [11:0] HTOTAL  = 12'(P_HTOTAL);
  localparam logic [3:0]  LOCK_N  = 4'(P_LOCK_FRAMES);
  localparam logic [10:0] CNT_MAX = 11'h7FF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_SYNC    = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic       hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d;
  logic [8:0] d1_q, d1_d;
  logic       hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d;

  logic [10:0] px_q, px_d, ln_q, ln_d, hc_q, hc_d;
  logic        hs_seen_q, hs_seen_d;
  logic [3:0]  gcnt_q, gcnt_d;

  logic       cap_wr_en_q, cap_wr_en_d;
  logic [9:0] cap_x_q, cap_x_d, cap_y_q, cap_y_d;
  logic [8:0] cap_data_q, cap_data_d;
  logic       cap_sof_q, cap_sof_d;
  logic       cap_locked_q, cap_locked_d;
  logic       cap_err_q, cap_err_d;
  logic [7:0] cap_err_cnt_q, cap_err_cnt_d;

  logic        vs_rise, hs_rise, de_rise, de_fall;
  logic        clr_cnt, in_chk, wr_try, wr_ok;
  logic        e_line, e_frame, e_hper, e_devs, e_gate, err_now, err_rep;
  logic [10:0] px_cur;

  assign vs_rise = vs1_q & ~vs2_q;
  assign hs_rise = hs1_q & ~hs2_q;
  assign de_rise = de1_q & ~de2_q;
  assign de_fall = ~de1_q & de2_q;

  // Two-stage input pipeline: stage 1 samples the pins, stage 2 gives the previous value for edge detection.
  always_comb begin
    hs1_d = VIN_HSYNC;
    vs1_d = VIN_VSYNC;
    de1_d = VIN_DE;
    d1_d  = VIN_DATA;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    de2_d = de1_q;
  end

  // Geometry checks; the pixel index of the current DE cycle restarts at 0 on the DE rising edge.
  always_comb begin
    clr_cnt = (state_q == S_IDLE) | ~REG_CAP_EN;
    in_chk  = (state_q == S_SYNC) | (state_q == S_LOCKED);
    px_cur  = de_rise ? 11'd0 : px_q;
    wr_try  = (state_q == S_LOCKED) & de1_q & REG_CAP_EN;
    e_line  = de_fall & (px_q != HDATA);
    e_frame = vs_rise & in_chk & (ln_q != VDATA);
    e_hper  = hs_rise & hs_seen_q & (({1'b0, hc_q} + 12'd1) != HTOTAL);
    e_devs  = de1_q & vs1_q;
    e_gate  = wr_try & ((px_cur >= HDATA) | (ln_q >= VDATA));
    err_now = e_line | e_frame | e_hper | e_devs | e_gate;
    err_rep = err_now & in_chk & REG_CAP_EN;
    wr_ok   = wr_try & ~err_now;
  end

  // Lock FSM: a fresh vsync starts qualification, LOCK_N clean frames lock, any error drops back.
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    if (!REG_CAP_EN) begin
      state_d = S_IDLE;
      gcnt_d  = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT_VS;
          gcnt_d  = 4'd0;
        end
        S_WAIT_VS: begin
          gcnt_d = 4'd0;
          if (vs_rise) state_d = S_SYNC;
        end
        S_SYNC: begin
          if (err_now) begin
            state_d = S_WAIT_VS;
            gcnt_d  = 4'd0;
          end else if (vs_rise) begin
            gcnt_d = gcnt_q + 4'd1;
            if ((gcnt_q + 4'd1) == LOCK_N) state_d = S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (err_now) state_d = S_WAIT_VS;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Pixel, line and hsync-period counters; all cleared while capture is idle or disabled.
  always_comb begin
    px_d      = px_q;
    ln_d      = ln_q;
    hc_d      = hc_q;
    hs_seen_d = hs_seen_q;
    if (clr_cnt) begin
      px_d      = 11'd0;
      ln_d      = 11'd0;
      hc_d      = 11'd0;
      hs_seen_d = 1'b0;
    end else begin
      if (de1_q) px_d = (px_cur == CNT_MAX) ? px_cur : px_cur + 11'd1;
      if (vs_rise) ln_d = 11'd0;
      else if (de_fall && ln_q != CNT_MAX) ln_d = ln_q + 11'd1;
      if (hs_rise) hc_d = 11'd0;
      else if (hc_q != CNT_MAX) hc_d = hc_q + 11'd1;
      // A period is only measurable once an hsync edge has been seen since the last resync.
      if (state_d == S_WAIT_VS && state_q != S_WAIT_VS) hs_seen_d = 1'b0;
      else if (hs_rise) hs_seen_d = 1'b1;
    end
  end

  // Output stage: coordinates and data hold between writes; error count saturates and survives disable.
  always_comb begin
    cap_wr_en_d   = wr_ok;
    cap_x_d       = wr_ok ? px_cur[9:0] : cap_x_q;
    cap_y_d       = wr_ok ? ln_q[9:0] : cap_y_q;
    cap_data_d    = wr_ok ? d1_q : cap_data_q;
    cap_sof_d     = wr_ok & (px_cur == 11'd0) & (ln_q == 11'd0);
    cap_locked_d  = (state_d == S_LOCKED);
    cap_err_d     = err_rep;
    cap_err_cnt_d = cap_err_cnt_q;
    if (err_rep && cap_err_cnt_q != 8'hFF) cap_err_cnt_d = cap_err_cnt_q + 8'd1;
  end

  // State register for the whole receiver.
  always_ff @(posedge CLK_40M or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      state_q       <= S_IDLE;
      hs1_q         <= 1'b0;
      vs1_q         <= 1'b0;
      de1_q         <= 1'b0;
      d1_q          <= 9'd0;
      hs2_q         <= 1'b0;
      vs2_q         <= 1'b0;
      de2_q         <= 1'b0;
      px_q          <= 11'd0;
      ln_q          <= 11'd0;
      hc_q          <= 11'd0;
      hs_seen_q     <= 1'b0;
      gcnt_q        <= 4'd0;
      cap_wr_en_q   <= 1'b0;
      cap_x_q       <= 10'd0;
      cap_y_q       <= 10'd0;
      cap_data_q    <= 9'd0;
      cap_sof_q     <= 1'b0;
      cap_locked_q  <= 1'b0;
      cap_err_q     <= 1'b0;
      cap_err_cnt_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      de1_q         <= de1_d;
      d1_q          <= d1_d;
      hs2_q         <= hs2_d;
      vs2_q         <= vs2_d;
      de2_q         <= de2_d;
      px_q          <= px_d;
      ln_q          <= ln_d;
      hc_q          <= hc_d;
      hs_seen_q     <= hs_seen_d;
      gcnt_q        <= gcnt_d;
      cap_wr_en_q   <= cap_wr_en_d;
      cap_x_q       <= cap_x_d;
      cap_y_q       <= cap_y_d;
      cap_data_q    <= cap_data_d;
      cap_sof_q     <= cap_sof_d;
      cap_locked_q  <= cap_locked_d;
      cap_err_q     <= cap_err_d;
      cap_err_cnt_q <= cap_err_cnt_d;
    end
  end

  assign CAP_WR_EN   = cap_wr_en_q;
  assign CAP_X       = cap_x_q;
  assign CAP_Y       = cap_y_q;
  assign CAP_DATA    = cap_data_q;
  assign CAP_SOF     = cap_sof_q;
  assign CAP_LOCKED  = cap_locked_q;
  assign CAP_ERR     = cap_err_q;
  assign CAP_ERR_CNT = cap_err_cnt_q;

endmodule

// File: tb/tb_vga_cap_rx.sv
// Directed bench for vga_cap_rx using a shrunken raster: 8 active pixels, 16-clock lines,
// 4 active lines, 7 lines per frame (vsync during line 5), lock after 2 good frames.
module tb_vga_cap_rx;

  logic       CLK_40M = 1'b0;
  logic       SYS_RST_N, REG_CAP_EN, VIN_HSYNC, VIN_VSYNC, VIN_DE;
  logic [8:0] VIN_DATA;
  logic       CAP_WR_EN, CAP_SOF, CAP_LOCKED, CAP_ERR;
  logic [9:0] CAP_X, CAP_Y;
  logic [8:0] CAP_DATA;
  logic [7:0] CAP_ERR_CNT;

  vga_cap_rx #(
    .P_HDATA(8), .P_HTOTAL(16), .P_VDATA(4), .P_LOCK_FRAMES(2)
  ) dut (
    .CLK_40M(CLK_40M), .SYS_RST_N(SYS_RST_N), .REG_CAP_EN(REG_CAP_EN),
    .VIN_HSYNC(VIN_HSYNC), .VIN_VSYNC(VIN_VSYNC), .VIN_DE(VIN_DE), .VIN_DATA(VIN_DATA),
    .CAP_WR_EN(CAP_WR_EN), .CAP_X(CAP_X), .CAP_Y(CAP_Y), .CAP_DATA(CAP_DATA),
    .CAP_SOF(CAP_SOF), .CAP_LOCKED(CAP_LOCKED), .CAP_ERR(CAP_ERR), .CAP_ERR_CNT(CAP_ERR_CNT)
  );

  always #5 CLK_40M = ~CLK_40M;

  int errors = 0, checks = 0;
  int wr_cnt = 0, sof_cnt = 0, last_x = -1, last_y = -1;
  int wr_unlocked = 0, lat_bad = 0, err_pulses = 0, err_locked = 0;
  int vs_cnt = 0, lock_vs = 0;
  int short_line = -1, short_hs_line = -1, drop_line = -1, rst_line = -1;
  logic       prev_de = 1'b0, prev_locked = 1'b0, drop_locked = 1'b1;
  logic [8:0] prev_data = 9'd0;
  logic [40:0] rst_snap = '1;
  logic [40:0] all_out;

  assign all_out = {CAP_WR_EN, CAP_X, CAP_Y, CAP_DATA, CAP_SOF, CAP_LOCKED, CAP_ERR, CAP_ERR_CNT};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: apply current inputs, sample outputs 1 time unit after the edge and log activity.
  task automatic step();
    logic       cur_de;
    logic [8:0] cur_dat;
    cur_de  = VIN_DE;
    cur_dat = VIN_DATA;
    @(posedge CLK_40M);
    #1;
    if (CAP_WR_EN) begin
      wr_cnt++;
      last_x = int'(CAP_X);
      last_y = int'(CAP_Y);
      if (!CAP_LOCKED) wr_unlocked++;
      if (!prev_de || CAP_DATA !== prev_data || CAP_DATA !== CAP_X[8:0]) lat_bad++;
    end
    if (CAP_SOF) sof_cnt++;
    if (CAP_ERR) begin
      err_pulses++;
      if (CAP_LOCKED) err_locked++;
    end
    if (CAP_LOCKED && !prev_locked && lock_vs == 0) lock_vs = vs_cnt;
    prev_locked = CAP_LOCKED;
    prev_de     = cur_de;
    prev_data   = cur_dat;
  endtask

  task automatic drive_line(input int l, input int de_len, input int htot, input bit vs_on);
    for (int c = 0; c < htot; c++) begin
      VIN_DE     = (c < de_len);
      VIN_HSYNC  = (c == 10 || c == 11);
      VIN_VSYNC  = vs_on;
      VIN_DATA   = 9'(c);
      REG_CAP_EN = !(l == drop_line && c >= 2 && c < 12);
      if (vs_on && c == 0) vs_cnt++;
      if (l == rst_line && c == 4) SYS_RST_N = 1'b0;
      if (l == rst_line && c == 7) SYS_RST_N = 1'b1;
      step();
      if (l == drop_line && c == 5) drop_locked = CAP_LOCKED;
      if (l == rst_line && c == 5) rst_snap = all_out;
    end
  endtask

  task automatic drive_frame();
    for (int l = 0; l < 7; l++)
      drive_line(l, (l < 4) ? ((l == short_line) ? 7 : 8) : 0,
                 (l == short_hs_line) ? 15 : 16, (l == 5));
  endtask

  initial begin
    int e0;
    SYS_RST_N = 1'b0; REG_CAP_EN = 1'b0;
    VIN_HSYNC = 1'b0; VIN_VSYNC = 1'b0; VIN_DE = 1'b0; VIN_DATA = 9'd0;
    repeat (3) step();
    chk("reset_outputs", 64'(all_out), 64'd0);
    SYS_RST_N = 1'b1;
    repeat (2) step();
    chk("idle_no_lock", 64'(CAP_LOCKED), 64'd0);

    // Initial lock: vsync of frame 1 resyncs, frames 2 and 3 are the good frames.
    drive_frame(); drive_frame();
    chk("no_lock_after_2vs", 64'(CAP_LOCKED), 64'd0);
    drive_frame();
    chk("lock_on_3rd_vs", 64'(lock_vs), 64'd3);
    chk("locked_high", 64'(CAP_LOCKED), 64'd1);

    // Full locked frame.
    wr_cnt = 0; sof_cnt = 0;
    drive_frame();
    chk("frame_writes", 64'(wr_cnt), 64'd32);
    chk("frame_sof", 64'(sof_cnt), 64'd1);
    chk("last_x", 64'(last_x), 64'd7);
    chk("last_y", 64'(last_y), 64'd3);
    chk("x_holds", 64'(CAP_X), 64'd7);
    chk("errcnt_clean", 64'(CAP_ERR_CNT), 64'd0);

    // Short line (7 DE cycles) on line 1.
    wr_cnt = 0; vs_cnt = 0; lock_vs = 0; e0 = err_pulses; short_line = 1;
    drive_frame();
    short_line = -1;
    chk("short_line_writes", 64'(wr_cnt), 64'd15);
    chk("short_line_errcnt", 64'(CAP_ERR_CNT), 64'd1);
    chk("short_line_unlocked", 64'(CAP_LOCKED), 64'd0);
    wr_cnt = 0;
    drive_frame(); drive_frame();
    chk("relock_no_writes", 64'(wr_cnt), 64'd0);
    chk("short_line_relock_vs", 64'(lock_vs), 64'd3);
    chk("short_line_one_pulse", 64'(err_pulses - e0), 64'd1);

    // One hsync period of 15 clocks.
    wr_cnt = 0; vs_cnt = 0; lock_vs = 0; short_hs_line = 0;
    drive_frame();
    short_hs_line = -1;
    chk("hper_writes", 64'(wr_cnt), 64'd16);
    chk("hper_errcnt", 64'(CAP_ERR_CNT), 64'd2);
    drive_frame(); drive_frame();
    chk("hper_relock_vs", 64'(lock_vs), 64'd3);

    // Capture enable dropped for 10 clocks mid-frame.
    vs_cnt = 0; lock_vs = 0; e0 = err_pulses; drop_line = 1;
    drive_frame();
    drop_line = -1;
    chk("drop_unlocked", 64'(drop_locked), 64'd0);
    chk("drop_no_lock_1vs", 64'(CAP_LOCKED), 64'd0);
    drive_frame(); drive_frame();
    chk("drop_relock_vs", 64'(lock_vs), 64'd3);
    chk("drop_errcnt_kept", 64'(CAP_ERR_CNT), 64'd2);
    chk("drop_no_err", 64'(err_pulses - e0), 64'd0);

    // Reset pulse mid-line while locked.
    vs_cnt = 0; lock_vs = 0; rst_line = 1;
    drive_frame();
    rst_line = -1;
    chk("midline_reset_outputs", 64'(rst_snap), 64'd0);
    chk("reset_errcnt", 64'(CAP_ERR_CNT), 64'd0);
    drive_frame(); drive_frame();
    chk("reset_relock_vs", 64'(lock_vs), 64'd3);

    // Error injection: each 2-clock vsync pulse with DE held high yields exactly one counted error.
    e0 = err_pulses;
    VIN_HSYNC = 1'b0; VIN_DATA = 9'd0; VIN_VSYNC = 1'b0; VIN_DE = 1'b1;
    step();
    for (int i = 0; i < 100; i++) begin
      VIN_VSYNC = 1'b1; step(); step();
      VIN_VSYNC = 1'b0; step();
    end
    step();
    chk("inject_100_cnt", 64'(CAP_ERR_CNT), 64'd100);
    chk("inject_100_pulses", 64'(err_pulses - e0), 64'd100);
    for (int i = 0; i < 200; i++) begin
      VIN_VSYNC = 1'b1; step(); step();
      VIN_VSYNC = 1'b0; step();
    end
    VIN_DE = 1'b0;
    step(); step();
    chk("inject_saturate", 64'(CAP_ERR_CNT), 64'd255);
    chk("inject_300_pulses", 64'(err_pulses - e0), 64'd300);

    chk("writes_only_locked", 64'(wr_unlocked), 64'd0);
    chk("write_latency_data", 64'(lat_bad), 64'd0);
    chk("err_drops_lock", 64'(err_locked), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
